// File: rtl/uart16550_pkg.sv
// Shared definitions for talking to a uart16550 slave: register map, LSR bit
// positions, the bridge FSM encoding and the single-transfer request format.
package uart16550_pkg;

    localparam logic [2:0] ADDR_RBR_THR = 3'd0;
    localparam logic [2:0] ADDR_DLL     = 3'd0;
    localparam logic [2:0] ADDR_IER     = 3'd1;
    localparam logic [2:0] ADDR_DLM     = 3'd1;
    localparam logic [2:0] ADDR_FCR     = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_LSR     = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;

    localparam logic [7:0] LCR_DLAB = 8'h80;

    // THRE guarantees room for a full 16-byte transmit FIFO.
    localparam logic [4:0] TX_CREDIT_MAX = 5'd16;

    typedef enum logic [3:0] {
        ST_INIT_LCR1,
        ST_INIT_DLL,
        ST_INIT_DLM,
        ST_INIT_LCR2,
        ST_INIT_FCR,
        ST_INIT_IER,
        ST_IDLE,
        ST_POLL,
        ST_RD_RBR,
        ST_WR_THR
    } bridge_state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } wb_req_t;

    function automatic wb_req_t wb_wr(input logic [2:0] adr, input logic [7:0] dat);
        wb_req_t r;
        r.we  = 1'b1;
        r.adr = adr;
        r.dat = dat;
        return r;
    endfunction

    function automatic wb_req_t wb_rd(input logic [2:0] adr);
        wb_req_t r;
        r.we  = 1'b0;
        r.adr = adr;
        r.dat = 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/wb_byte_master.sv
// Single-transfer Wishbone master: takes one request when idle, holds the bus
// until ack, and always leaves at least one cycle with cyc low between cycles.
module wb_byte_master
    import uart16550_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req_valid_i,
    input  wb_req_t    req_i,
    output logic       ready_o,
    output logic       done_o,
    output logic [7:0] rdata_o,

    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    output logic [3:0] wbm_sel_o,
    input  logic       wbm_ack_i
);

    logic    cyc_q, cyc_d;
    wb_req_t xfer_q, xfer_d;

    // cyc drops on the ack edge, and a new request is only taken while cyc is
    // low, so the earliest restart leaves exactly one idle cycle.
    always_comb begin
        cyc_d  = cyc_q;
        xfer_d = xfer_q;
        if (!cyc_q) begin
            if (req_valid_i) begin
                cyc_d  = 1'b1;
                xfer_d = req_i;
            end
        end else if (wbm_ack_i) begin
            cyc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= 1'b0;
            xfer_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            xfer_q <= xfer_d;
        end
    end

    assign ready_o   = !cyc_q;
    assign done_o    = cyc_q && wbm_ack_i;
    assign rdata_o   = wbm_dat_i;

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = xfer_q.we;
    assign wbm_adr_o = xfer_q.adr;
    assign wbm_dat_o = xfer_q.dat;
    assign wbm_sel_o = 4'b0001;

endmodule

// File: rtl/uart16550_stream_bridge.sv
// Programs a uart16550 after reset, then polls LSR to shuttle bytes between
// TX/RX valid/ready streams and the UART's THR/RBR registers.
module uart16550_stream_bridge
    import uart16550_pkg::*;
#(
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VALUE = 8'h03,
    parameter logic [7:0]  FCR_VALUE = 8'h07
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,

    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    output logic [3:0] wbm_sel_o,
    input  logic       wbm_ack_i,

    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,

    output logic [7:0] rx_data_o,
    output logic       rx_err_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,

    output logic       init_done_o
);

    bridge_state_e state_q, state_d;
    logic          issued_q, issued_d;
    logic [4:0]    credit_q, credit_d;
    logic          lsr_err_q, lsr_err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_err_q, rx_err_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_ready_q, tx_ready_d;
    logic          init_done_q, init_done_d;

    logic          bus_valid;
    wb_req_t       bus_req;
    logic          bus_ready;
    logic          bus_done;
    logic [7:0]    bus_rdata;
    logic [4:0]    credit_avail;

    wb_byte_master u_wb_master (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .req_valid_i (bus_valid),
        .req_i       (bus_req),
        .ready_o     (bus_ready),
        .done_o      (bus_done),
        .rdata_o     (bus_rdata),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i)
    );

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        credit_d     = credit_q;
        lsr_err_d    = lsr_err_q;
        rx_data_d    = rx_data_q;
        rx_err_d     = rx_err_q;
        rx_valid_d   = rx_valid_q;
        tx_ready_d   = 1'b0;
        init_done_d  = init_done_q;
        credit_avail = credit_q;

        case (state_q)
            ST_INIT_LCR1: bus_req = wb_wr(ADDR_LCR, LCR_VALUE | LCR_DLAB);
            ST_INIT_DLL:  bus_req = wb_wr(ADDR_DLL, DIVISOR[7:0]);
            ST_INIT_DLM:  bus_req = wb_wr(ADDR_DLM, DIVISOR[15:8]);
            ST_INIT_LCR2: bus_req = wb_wr(ADDR_LCR, LCR_VALUE);
            ST_INIT_FCR:  bus_req = wb_wr(ADDR_FCR, FCR_VALUE);
            ST_INIT_IER:  bus_req = wb_wr(ADDR_IER, 8'h00);
            ST_POLL:      bus_req = wb_rd(ADDR_LSR);
            ST_RD_RBR:    bus_req = wb_rd(ADDR_RBR_THR);
            ST_WR_THR:    bus_req = wb_wr(ADDR_RBR_THR, tx_data_i);
            default:      bus_req = '0;
        endcase

        // Every non-idle state owns exactly one bus transfer.
        bus_valid = (state_q != ST_IDLE) && !issued_q;
        if (bus_valid && bus_ready) begin
            issued_d = 1'b1;
        end

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            state_d = ST_POLL;
        end

        if (bus_done) begin
            issued_d = 1'b0;
            case (state_q)
                ST_INIT_LCR1: state_d = ST_INIT_DLL;
                ST_INIT_DLL:  state_d = ST_INIT_DLM;
                ST_INIT_DLM:  state_d = ST_INIT_LCR2;
                ST_INIT_LCR2: state_d = ST_INIT_FCR;
                ST_INIT_FCR:  state_d = ST_INIT_IER;
                ST_INIT_IER: begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
                ST_POLL: begin
                    lsr_err_d = |bus_rdata[LSR_BI:LSR_OE];
                    if (bus_rdata[LSR_DR] && !rx_valid_q) begin
                        state_d = ST_RD_RBR;
                    end else begin
                        // Credit is only refilled by an observed THRE.
                        if (bus_rdata[LSR_THRE]) begin
                            credit_avail = TX_CREDIT_MAX;
                        end
                        credit_d = credit_avail;
                        if ((credit_avail != 5'd0) && tx_valid_i) begin
                            state_d = ST_WR_THR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_RD_RBR: begin
                    rx_data_d  = bus_rdata;
                    rx_err_d   = lsr_err_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                ST_WR_THR: begin
                    credit_d   = (credit_q != 5'd0) ? credit_q - 5'd1 : 5'd0;
                    tx_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_INIT_LCR1;
            issued_q    <= 1'b0;
            credit_q    <= 5'd0;
            lsr_err_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_err_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            credit_q    <= credit_d;
            lsr_err_q   <= lsr_err_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_err_o    = rx_err_q;
    assign rx_valid_o  = rx_valid_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_uart16550_stream_bridge.sv
// Randomized bench: a uart16550 register model answers the bus, scoreboards
// hold the expected init writes, THR bytes and RX stream bytes.
module tb_uart16550_stream_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
    logic [3:0] wbm_sel_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_err_o, rx_valid_o, rx_ready_i, init_done_o;

    always #5 clk = ~clk;

    uart16550_stream_bridge dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_err_o    (rx_err_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .init_done_o (init_done_o)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] e;
    } rxb_t;

    rxb_t        uart_rxq[$];
    rxb_t        exp_rx[$];
    logic [10:0] exp_init[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_src_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    logic thre = 1'b0, thre_drop = 1'b0, ack_allow = 1'b1, hold_thr = 1'b0;
    logic rx_ready_en = 1'b1, last_poll = 1'b0;
    int   burst_cnt = 0, thr_cnt = 0, rbr_cnt = 0, txr_cnt = 0;
    time  rbr_t = 0, thr_t = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_init();
        exp_init.push_back({3'd3, 8'h83});
        exp_init.push_back({3'd0, 8'h1B});
        exp_init.push_back({3'd1, 8'h00});
        exp_init.push_back({3'd3, 8'h03});
        exp_init.push_back({3'd2, 8'h07});
        exp_init.push_back({3'd1, 8'h00});
    endtask

    task automatic inject_rx(input logic [7:0] d, input logic [3:0] e);
        rxb_t r;
        r.d = d;
        r.e = e;
        uart_rxq.push_back(r);
        exp_rx.push_back(r);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_src_q.push_back(b);
        exp_tx.push_back(b);
    endtask

    // UART register model; it also acts as the bus-side monitor.
    task automatic bus_access();
        logic [10:0] e;
        logic [7:0]  lsr;
        rxb_t        r;
        check("sel_const", {28'd0, wbm_sel_o}, 32'h1);
        if (exp_init.size() > 0) begin
            e = exp_init.pop_front();
            check("init_access", {21'd0, wbm_we_o, wbm_adr_o, wbm_dat_o}, {21'd0, 1'b1, e});
            check("init_done_early", {31'd0, init_done_o}, 32'd0);
            last_poll = 1'b0;
        end else if (wbm_we_o) begin
            check("thr_addr", {29'd0, wbm_adr_o}, 32'd0);
            check("thr_after_poll", {31'd0, last_poll}, 32'd1);
            check("thr_expected", {31'd0, exp_tx.size() > 0}, 32'd1);
            if (exp_tx.size() > 0) check("thr_data", {24'd0, wbm_dat_o}, {24'd0, exp_tx.pop_front()});
            thr_cnt++;
            burst_cnt++;
            thr_t = $time;
            check("thr_burst_le16", {31'd0, burst_cnt <= 16}, 32'd1);
            if (thre_drop) thre = 1'b0;
            last_poll = 1'b0;
        end else if (wbm_adr_o == 3'd5) begin
            lsr = 8'h00;
            lsr[5] = thre;
            lsr[6] = thre;
            if (uart_rxq.size() > 0) begin
                lsr[0]   = 1'b1;
                lsr[4:1] = uart_rxq[0].e;
            end
            wbm_dat_i = lsr;
            if (thre) burst_cnt = 0;
            last_poll = 1'b1;
        end else if (wbm_adr_o == 3'd0) begin
            check("rbr_after_poll", {31'd0, last_poll}, 32'd1);
            check("rbr_when_holding_empty", {31'd0, rx_valid_o}, 32'd0);
            check("rbr_has_data", {31'd0, uart_rxq.size() > 0}, 32'd1);
            if (uart_rxq.size() > 0) begin
                r = uart_rxq.pop_front();
                wbm_dat_i = r.d;
            end
            rbr_cnt++;
            rbr_t = $time;
            last_poll = 1'b0;
        end else begin
            check("read_addr_legal", {29'd0, wbm_adr_o}, 32'd5);
            last_poll = 1'b0;
        end
    endtask

    initial begin : slave
        wbm_ack_i = 1'b0;
        wbm_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            if (rst_n && wbm_cyc_o && wbm_stb_o && ack_allow &&
                !(hold_thr && wbm_we_o && wbm_adr_o == 3'd0) &&
                $urandom_range(0, 2) != 0) begin
                wbm_ack_i = 1'b1;
                bus_access();
            end
        end
    end

    initial begin : tx_source
        logic hs;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid_i && tx_ready_o;
            @(posedge clk);
            #1;
            if (hs && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
            if (tx_src_q.size() > 0) begin
                tx_valid_i = 1'b1;
                tx_data_i  = tx_src_q[0];
            end else begin
                tx_valid_i = 1'b0;
            end
        end
    end

    initial begin : tx_ready_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_ready_o) begin
                txr_cnt++;
                check("tx_ready_one_cycle", {31'd0, prev}, 32'd0);
                check("tx_ready_with_valid", {31'd0, tx_valid_i}, 32'd1);
            end
            prev = tx_ready_o;
        end
    end

    initial begin : rx_sink
        rxb_t e;
        rx_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid_o && rx_ready_i) begin
                check("rx_expected", {31'd0, exp_rx.size() > 0}, 32'd1);
                if (exp_rx.size() > 0) begin
                    e = exp_rx.pop_front();
                    check("rx_data", {24'd0, rx_data_o}, {24'd0, e.d});
                    check("rx_err", {31'd0, rx_err_o}, {31'd0, |e.e});
                end
            end
            @(posedge clk);
            #1;
            rx_ready_i = rx_ready_en && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_init(input string name);
        for (int c = 0; c < 500 && !init_done_o; c++) @(negedge clk);
        check(name, {31'd0, init_done_o}, 32'd1);
        check("init_all_writes", exp_init.size(), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (exp_tx.size() == 0 && exp_rx.size() == 0 && tx_src_q.size() == 0 && !rx_valid_o) break;
            @(negedge clk);
        end
        check(name, {31'd0, exp_tx.size() == 0 && exp_rx.size() == 0 && !rx_valid_o}, 32'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int thr0, r0, txr0, k, nj;
        time t0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("rst_bus", {20'd0, wbm_we_o, wbm_adr_o, wbm_dat_o}, 32'd0);
        check("rst_sel", {28'd0, wbm_sel_o}, 32'h1);
        check("rst_streams", {20'd0, tx_ready_o, rx_valid_o, rx_err_o, init_done_o, rx_data_o}, 32'd0);

        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_done");

        // TX burst: THRE seen once, then low -> 16 writes only.
        thr0 = thr_cnt;
        thre = 1'b1;
        thre_drop = 1'b1;
        for (int i = 0; i < 20; i++) push_tx(i[7:0]);
        for (int c = 0; c < 4000 && (thr_cnt - thr0) < 16; c++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("tx_burst_16", thr_cnt - thr0, 32'd16);
        check("tx_burst_left4", exp_tx.size(), 32'd4);
        thre_drop = 1'b0;
        thre = 1'b1;
        wait_drain("tx_burst_tail", 3000);
        check("tx_total_20", thr_cnt - thr0, 32'd20);

        // RX backpressure.
        rx_ready_en = 1'b0;
        repeat (3) @(posedge clk);
        r0 = rbr_cnt;
        inject_rx(8'hA5, 4'h0);
        inject_rx(8'h5A, 4'h0);
        repeat (50) @(negedge clk);
        check("rx_bp_valid", {31'd0, rx_valid_o}, 32'd1);
        check("rx_bp_data", {24'd0, rx_data_o}, 32'hA5);
        check("rx_bp_one_read", rbr_cnt - r0, 32'd1);
        rx_ready_en = 1'b1;
        wait_drain("rx_bp_drain", 2000);
        check("rx_bp_two_reads", rbr_cnt - r0, 32'd2);

        // Simultaneous RX and TX in one poll: RX goes first.
        ack_allow = 1'b0;
        repeat (2) @(posedge clk);
        t0 = $time;
        inject_rx(8'h3C, 4'h0);
        push_tx(8'hC3);
        repeat (3) @(posedge clk);
        ack_allow = 1'b1;
        wait_drain("sim_drain", 2000);
        check("sim_rx_before_tx", {31'd0, rbr_t > t0 && thr_t > rbr_t}, 32'd1);

        // Error flag follows the poll that preceded each byte.
        thre = 1'b0;
        inject_rx(8'h81, 4'b0100);
        inject_rx(8'h18, 4'h0);
        wait_drain("err_drain", 2000);

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 3);
            if (k <= 1) begin
                if ($urandom_range(0, 3) == 0) inject_rx(8'($urandom), 4'($urandom_range(1, 15)));
                else inject_rx(8'($urandom), 4'h0);
            end
            if (k >= 1) begin
                nj = $urandom_range(1, 3);
                for (int j = 0; j < nj; j++) push_tx(8'($urandom));
            end
            thre = 1'($urandom_range(0, 1));
            rx_ready_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        thre = 1'b1;
        rx_ready_en = 1'b1;
        wait_drain("random_drain", 6000);

        // Reset while a THR write waits for ack.
        hold_thr = 1'b1;
        thre = 1'b1;
        push_tx(8'hEE);
        for (int c = 0; c < 500 && !(wbm_cyc_o && wbm_we_o && wbm_adr_o == 3'd0); c++) @(negedge clk);
        check("thr_write_pending", {31'd0, wbm_cyc_o && wbm_we_o}, 32'd1);
        txr0 = txr_cnt;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("async_rst_init_done", {31'd0, init_done_o}, 32'd0);
        burst_cnt = 0;
        push_init();
        hold_thr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit_done");
        check("rst_no_tx_ready", txr_cnt - txr0, 32'd0);
        wait_drain("after_reset_drain", 2000);

        repeat (20) @(negedge clk);
        check("tx_ready_count", txr_cnt, thr_cnt);
        check("uart_rx_empty", uart_rxq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
